// File: rtl/afd_sched.sv
// afd_sched: sequencer for the afd sum-of-absolute-differences accumulator.
// Runs a full-search block match: on start, every one of NUM_CAND candidate
// blocks is streamed against a single original block, NUM_PARTITION sample-pair
// beats per candidate. Each candidate's accumulated SAD is captured, and the
// minimum SAD is tracked together with the index of the candidate that gave it.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous reset, active-low
//   start      one-cycle search request, ignored while busy or in the done cycle
//   abort      synchronous cancel, returns to idle without done / sad_valid
//   busy       high from start acceptance until done
//   done       one-cycle pulse, search complete
//   best_sad   minimum SAD seen so far in the current/last search
//   best_idx   candidate index of best_sad (ties keep the lower index)
//   sad_valid  one-cycle pulse per captured candidate SAD
//   sad_out    captured SAD, valid with sad_valid
//   cand_addr  candidate memory pair address (word = a1:a0)
//   ori_addr   original memory pair address (word = b1:b0)
//   afd_en     to afd.en, aligned to the read data returned by the memories
//   afd_acum   to afd.acum, low on beat 0 of each candidate
//   afd_out    from afd.out_afd
module afd_sched #(
  parameter int WIDTH         = 8,
  parameter int NUM_PARTITION = 1,
  parameter int NUM_CAND      = 16,
  parameter int ADDR_W        = 16,
  parameter int IDX_W         = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [WIDTH+7:0]   best_sad,
  output logic [IDX_W-1:0]   best_idx,
  output logic               sad_valid,
  output logic [WIDTH+7:0]   sad_out,
  output logic [ADDR_W-1:0]  cand_addr,
  output logic [ADDR_W-1:0]  ori_addr,
  output logic               afd_en,
  output logic               afd_acum,
  input  logic [WIDTH+7:0]   afd_out
);

  localparam int BEAT_W = (NUM_PARTITION > 1) ? $clog2(NUM_PARTITION) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_PARTITION - 1);
  localparam logic [IDX_W-1:0]  LAST_CAND = IDX_W'(NUM_CAND - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_CAPT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [BEAT_W-1:0] beat;
  logic [IDX_W-1:0]  cand;
  logic              last_beat;
  logic              last_cand;
  logic              better;

  assign last_beat = (beat == LAST_BEAT);
  assign last_cand = (cand == LAST_CAND);
  assign better    = (cand == '0) || (afd_out < best_sad);

  assign busy = (state == S_RUN) || (state == S_DRAIN) || (state == S_CAPT);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (last_beat) state_nx = S_DRAIN;
      S_DRAIN: state_nx = S_CAPT;
      S_CAPT:  state_nx = last_cand ? S_DONE : S_RUN;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Addresses are kept as running counters rather than cand*NUM_PARTITION+beat:
  // the first address of candidate c+1 is always one past the last address of
  // candidate c, so a single increment in CAPT moves to the next block.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat      <= '0;
      cand      <= '0;
      cand_addr <= '0;
      ori_addr  <= '0;
      afd_en    <= 1'b0;
      afd_acum  <= 1'b0;
      sad_valid <= 1'b0;
      sad_out   <= '0;
      best_sad  <= '0;
      best_idx  <= '0;
    end else begin
      // afd control lags the address issue by the one-cycle memory latency
      afd_en    <= (state == S_RUN) && !abort;
      afd_acum  <= (state == S_RUN) && (beat != '0) && !abort;
      sad_valid <= (state == S_CAPT) && !abort;
      if (!abort) begin
        case (state)
          S_IDLE: begin
            if (start) begin
              beat      <= '0;
              cand      <= '0;
              cand_addr <= '0;
              ori_addr  <= '0;
            end
          end
          S_RUN: begin
            if (!last_beat) begin
              beat      <= beat + BEAT_W'(1);
              cand_addr <= cand_addr + ADDR_W'(1);
              ori_addr  <= ori_addr + ADDR_W'(1);
            end
          end
          S_CAPT: begin
            sad_out <= afd_out;
            if (better) begin
              best_sad <= afd_out;
              best_idx <= cand;
            end
            if (!last_cand) begin
              cand      <= cand + IDX_W'(1);
              beat      <= '0;
              cand_addr <= cand_addr + ADDR_W'(1);
              ori_addr  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_afd_sched.sv
// Testbench for afd_sched. Two instances are built: instance 0 with
// NUM_PARTITION=1, NUM_CAND=4 and instance 1 with NUM_PARTITION=3, NUM_CAND=2.
// Each has its own synchronous sample memories and a model of the afd
// accumulator. Expected SADs and best results come from a direct sum of
// absolute differences over the memory contents.
module tb_afd_sched;

  localparam int WIDTH  = 8;
  localparam int SAD_W  = WIDTH + 8;
  localparam int ADDR_W = 16;
  localparam int IDX_W  = 8;
  localparam int NP0 = 1;
  localparam int NC0 = 4;
  localparam int NP1 = 3;
  localparam int NC1 = 2;

  logic clk = 1'b0;
  logic rst;
  logic start_v [2];
  logic abort_v [2];
  logic busy_v  [2];
  logic done_v  [2];
  logic sval_v  [2];
  logic en_v    [2];
  logic acum_v  [2];
  logic [SAD_W-1:0]  best_sad_v [2];
  logic [SAD_W-1:0]  sad_v      [2];
  logic [IDX_W-1:0]  best_idx_v [2];
  logic [ADDR_W-1:0] caddr_v    [2];
  logic [ADDR_W-1:0] oaddr_v    [2];

  logic [15:0] cmem [2][16];
  logic [15:0] omem [2][4];
  logic [SAD_W-1:0] prev_sad [2];
  logic [IDX_W-1:0] prev_idx [2];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic int np_of(input int k);
    return (k == 0) ? NP0 : NP1;
  endfunction

  function automatic int nc_of(input int k);
    return (k == 0) ? NC0 : NC1;
  endfunction

  function automatic logic [SAD_W-1:0] pair_sad(input logic [15:0] a, input logic [15:0] b);
    int d1;
    int d0;
    d1 = int'(a[15:8]) - int'(b[15:8]);
    d0 = int'(a[7:0]) - int'(b[7:0]);
    if (d1 < 0) d1 = -d1;
    if (d0 < 0) d0 = -d0;
    return SAD_W'(d1 + d0);
  endfunction

  function automatic logic [SAD_W-1:0] cand_sad(input int k, input int c);
    int s;
    int np;
    s  = 0;
    np = np_of(k);
    for (int b = 0; b < np; b++) s += int'(pair_sad(cmem[k][c*np+b], omem[k][b]));
    return SAD_W'(s);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int NP = (g == 0) ? NP0 : NP1;
    localparam int NC = (g == 0) ? NC0 : NC1;
    logic              d_busy, d_done, d_sval, d_en, d_acum;
    logic [SAD_W-1:0]  d_best_sad, d_sad, d_acc;
    logic [IDX_W-1:0]  d_best_idx;
    logic [ADDR_W-1:0] d_caddr, d_oaddr;
    logic [15:0]       cq, oq;

    afd_sched #(
      .WIDTH(WIDTH), .NUM_PARTITION(NP), .NUM_CAND(NC),
      .ADDR_W(ADDR_W), .IDX_W(IDX_W)
    ) u_dut (
      .clk(clk), .rst(rst), .start(start_v[g]), .abort(abort_v[g]),
      .busy(d_busy), .done(d_done), .best_sad(d_best_sad), .best_idx(d_best_idx),
      .sad_valid(d_sval), .sad_out(d_sad), .cand_addr(d_caddr), .ori_addr(d_oaddr),
      .afd_en(d_en), .afd_acum(d_acum), .afd_out(d_acc)
    );

    // synchronous memories, one-cycle read latency
    always @(posedge clk) begin
      cq <= cmem[g][d_caddr[3:0]];
      oq <= omem[g][d_oaddr[1:0]];
    end

    // afd accumulator: restarts on !acum, adds |a1-b1|+|a0-b0| when enabled
    always @(posedge clk or negedge rst) begin
      if (!rst) d_acc <= '0;
      else if (d_en) d_acc <= (d_acum ? d_acc : '0) + pair_sad(cq, oq);
    end

    assign busy_v[g]     = d_busy;
    assign done_v[g]     = d_done;
    assign sval_v[g]     = d_sval;
    assign en_v[g]       = d_en;
    assign acum_v[g]     = d_acum;
    assign best_sad_v[g] = d_best_sad;
    assign sad_v[g]      = d_sad;
    assign best_idx_v[g] = d_best_idx;
    assign caddr_v[g]    = d_caddr;
    assign oaddr_v[g]    = d_oaddr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input int k);
    check("rst_busy", 32'(busy_v[k]), 0);
    check("rst_done", 32'(done_v[k]), 0);
    check("rst_sval", 32'(sval_v[k]), 0);
    check("rst_en", 32'(en_v[k]), 0);
    check("rst_acum", 32'(acum_v[k]), 0);
    check("rst_best_sad", 32'(best_sad_v[k]), 0);
    check("rst_best_idx", 32'(best_idx_v[k]), 0);
    check("rst_sad_out", 32'(sad_v[k]), 0);
    check("rst_caddr", 32'(caddr_v[k]), 0);
    check("rst_oaddr", 32'(oaddr_v[k]), 0);
  endtask

  // One search on instance k. Cycle 0 is the first cycle after the edge that
  // accepts start; each candidate takes NP+2 cycles and done is expected in
  // cycle NC*(NP+2). poke_at pulses start in that cycle; abort_at asserts
  // abort in that cycle (-1 disables either).
  task automatic run_search(input int k, input int poke_at, input int abort_at);
    int np, nc, t, total, ncap, c, p;
    logic [SAD_W-1:0] exp_sad [4];
    logic [SAD_W-1:0] eb;
    logic [IDX_W-1:0] ei;
    np    = np_of(k);
    nc    = nc_of(k);
    t     = np + 2;
    total = nc * t;
    for (int i = 0; i < nc; i++) exp_sad[i] = cand_sad(k, i);
    ncap = nc;
    if (abort_at >= 0) begin
      ncap = 0;
      for (int i = 0; i < nc; i++) if (i*t + t - 1 < abort_at) ncap++;
    end
    eb = prev_sad[k];
    ei = prev_idx[k];
    for (int i = 0; i < ncap; i++) begin
      if (i == 0 || exp_sad[i] < eb) begin
        eb = exp_sad[i];
        ei = IDX_W'(i);
      end
    end
    prev_sad[k] = eb;
    prev_idx[k] = ei;

    @(posedge clk); #1 start_v[k] = 1'b1;
    @(posedge clk); #1 start_v[k] = 1'b0;
    for (int cyc = 0; cyc <= total; cyc++) begin
      @(negedge clk);
      if (abort_at >= 0 && cyc == abort_at + 1) begin
        abort_v[k] = 1'b0;
        check("abort_busy", 32'(busy_v[k]), 0);
        check("abort_en", 32'(en_v[k]), 0);
        check("abort_acum", 32'(acum_v[k]), 0);
        check("abort_sval", 32'(sval_v[k]), 0);
        repeat (4) begin
          @(negedge clk);
          check("abort_done", 32'(done_v[k]), 0);
          check("abort_sval", 32'(sval_v[k]), 0);
          check("abort_busy", 32'(busy_v[k]), 0);
        end
        check("abort_best_sad", 32'(best_sad_v[k]), 32'(eb));
        check("abort_best_idx", 32'(best_idx_v[k]), 32'(ei));
        return;
      end
      c = cyc / t;
      p = cyc % t;
      check("busy", 32'(busy_v[k]), 32'(cyc < total));
      check("done", 32'(done_v[k]), 32'(cyc == total));
      check("afd_en", 32'(en_v[k]), 32'(cyc < total && p >= 1 && p <= np));
      check("afd_acum", 32'(acum_v[k]), 32'(cyc < total && p >= 2 && p <= np));
      check("sad_valid", 32'(sval_v[k]), 32'(cyc > 0 && p == 0));
      if (cyc > 0 && p == 0) check("sad_out", 32'(sad_v[k]), 32'(exp_sad[c-1]));
      if (cyc < total && p < np) begin
        check("cand_addr", 32'(caddr_v[k]), 32'(c*np + p));
        check("ori_addr", 32'(oaddr_v[k]), 32'(p));
      end
      start_v[k] = (cyc == poke_at);
      if (cyc == abort_at) abort_v[k] = 1'b1;
    end
    check("best_sad", 32'(best_sad_v[k]), 32'(eb));
    check("best_idx", 32'(best_idx_v[k]), 32'(ei));
    @(negedge clk);
    start_v[k] = 1'b0;
    check("post_done", 32'(done_v[k]), 0);
    check("post_busy", 32'(busy_v[k]), 0);
    check("post_sval", 32'(sval_v[k]), 0);
  endtask

  task automatic fill_rand(input int k);
    for (int i = 0; i < 16; i++) cmem[k][i] = 16'($urandom);
    for (int i = 0; i < 4; i++) omem[k][i] = 16'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start_v[k]  = 1'b0;
      abort_v[k]  = 1'b0;
      prev_sad[k] = '0;
      prev_idx[k] = '0;
      for (int i = 0; i < 16; i++) cmem[k][i] = '0;
      for (int i = 0; i < 4; i++) omem[k][i] = '0;
    end
    #3;
    check_zero(0);
    check_zero(1);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);

    // SADs 30,12,12,40: tie keeps candidate 1
    omem[0][0] = {8'd100, 8'd50};
    cmem[0][0] = {8'd80,  8'd60};
    cmem[0][1] = {8'd106, 8'd44};
    cmem[0][2] = {8'd100, 8'd62};
    cmem[0][3] = {8'd140, 8'd50};
    run_search(0, -1, -1);

    // three-beat candidates: 18 then 20
    for (int i = 0; i < 3; i++) omem[1][i] = '0;
    for (int i = 0; i < 3; i++) cmem[1][i] = {8'd5, 8'd1};
    cmem[1][3] = {8'd7, 8'd0};
    cmem[1][4] = {8'd7, 8'd0};
    cmem[1][5] = {8'd3, 8'd3};
    run_search(1, -1, -1);

    // descending SADs with a start pulse in the middle of the search
    omem[0][0] = '0;
    cmem[0][0] = {8'd50, 8'd0};
    cmem[0][1] = {8'd40, 8'd0};
    cmem[0][2] = {8'd30, 8'd0};
    cmem[0][3] = {8'd20, 8'd0};
    run_search(0, 5, -1);
    // start coincident with the done cycle
    run_search(0, NC0*(NP0+2), -1);

    // abort in the second RUN cycle of candidate 1, then a clean search
    run_search(1, -1, NP1 + 2 + 1);
    run_search(1, -1, -1);

    // asynchronous reset in the DRAIN cycle of candidate 1
    @(posedge clk); #1 start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("drain_en", 32'(en_v[0]), 1);
    #2 rst = 1'b0;
    #1 check_zero(0);
    check_zero(1);
    @(negedge clk); rst = 1'b1;
    prev_sad[0] = '0; prev_idx[0] = '0;
    prev_sad[1] = '0; prev_idx[1] = '0;
    repeat (3) begin
      @(negedge clk);
      check("idle_en", 32'(en_v[0]), 0);
      check("idle_busy", 32'(busy_v[0]), 0);
    end

    // identical blocks -> SAD 0 everywhere
    omem[0][0] = 16'h5A3C;
    for (int i = 0; i < 4; i++) cmem[0][i] = 16'h5A3C;
    run_search(0, -1, -1);
    // largest possible SAD, 2*255*3 = 1530
    for (int i = 0; i < 3; i++) omem[1][i] = 16'h0000;
    for (int i = 0; i < 6; i++) cmem[1][i] = 16'hFFFF;
    run_search(1, -1, -1);

    for (int it = 0; it < 12; it++) begin
      int k, mode, tot;
      k    = it % 2;
      fill_rand(k);
      tot  = nc_of(k) * (np_of(k) + 2);
      mode = int'($urandom_range(0, 2));
      if (mode == 1) run_search(k, int'($urandom_range(0, tot)), -1);
      else if (mode == 2) run_search(k, -1, int'($urandom_range(0, tot - 1)));
      else run_search(k, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
